// File: rtl/midi_note_decoder.sv
// midi_note_decoder
//   Parses a serial MIDI byte stream into note events for a monophonic
//   envelope generator. Last-note priority: every accepted note-on takes
//   over the held note. A note-off only releases the note that is held.
//
// Ports
//   clk         in   system clock
//   rst_b       in   synchronous active-low reset
//   byte_in     in   [7:0] received MIDI byte
//   byte_valid  in   byte_in is valid this cycle
//   note_on     out  one-cycle strobe: a new note started
//   note_off    out  one-cycle strobe: the held note was released
//   note        out  [6:0] last note number started
//   velocity    out  [6:0] velocity of the last note-on
//   gate        out  high while a note is held
//   err_count   out  [7:0] data bytes dropped for lack of a status, saturating
//
// Handshake: byte_valid/byte_in form a valid-only stream. There is no ready,
// so every cycle with byte_valid high consumes exactly one byte.
//
// The parser state is held in state_q (type state_t). A bind checker can
// observe it there.

module midi_note_decoder #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       note_on,
    output logic       note_off,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       gate,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        WAIT_STATUS,
        DATA1,
        DATA2,
        SYSEX,
        SKIP
    } state_t;

    state_t     state_q, state_n;
    logic [7:0] rs_q, rs_n;              // running status byte
    logic       rs_valid_q, rs_valid_n;
    logic [6:0] d1_q, d1_n;
    logic [1:0] skip_q, skip_n;          // data bytes still to discard in SKIP
    logic [7:0] err_q, err_n;
    logic [6:0] note_q, note_n;
    logic [6:0] vel_q, vel_n;
    logic       gate_q, gate_n;
    logic       on_q, on_n;
    logic       off_q, off_n;

    logic       is_realtime;
    logic       is_status;
    logic       one_byte_msg;
    logic       chan_ok;
    logic       complete;
    logic [6:0] msg_d1;
    logic [6:0] msg_d2;

    assign is_realtime  = (byte_in >= 8'hF8);
    assign is_status    = byte_in[7];
    // Program change and channel pressure carry a single data byte.
    assign one_byte_msg = (rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD);
    assign chan_ok      = OMNI || (rs_q[3:0] == CHANNEL);

    always_comb begin
        state_n    = state_q;
        rs_n       = rs_q;
        rs_valid_n = rs_valid_q;
        d1_n       = d1_q;
        skip_n     = skip_q;
        err_n      = err_q;
        note_n     = note_q;
        vel_n      = vel_q;
        gate_n     = gate_q;
        on_n       = 1'b0;
        off_n      = 1'b0;
        complete   = 1'b0;
        msg_d1     = d1_q;
        msg_d2     = 7'd0;

        if (byte_valid && !is_realtime) begin
            if (is_status) begin
                // Any status byte abandons whatever message was in progress.
                if (byte_in < 8'hF0) begin
                    rs_n       = byte_in;
                    rs_valid_n = 1'b1;
                    state_n    = DATA1;
                end else begin
                    case (byte_in)
                        8'hF0: begin
                            rs_valid_n = 1'b0;
                            state_n    = SYSEX;
                        end
                        8'hF1, 8'hF3: begin
                            rs_valid_n = 1'b0;
                            skip_n     = 2'd1;
                            state_n    = SKIP;
                        end
                        8'hF2: begin
                            rs_valid_n = 1'b0;
                            skip_n     = 2'd2;
                            state_n    = SKIP;
                        end
                        8'hF7: begin
                            state_n = WAIT_STATUS;
                        end
                        default: begin
                            rs_valid_n = 1'b0;
                            state_n    = WAIT_STATUS;
                        end
                    endcase
                end
            end else begin
                case (state_q)
                    WAIT_STATUS, DATA1: begin
                        // In WAIT_STATUS, running status lets the byte start a new message.
                        if (state_q == DATA1 || rs_valid_q) begin
                            d1_n = byte_in[6:0];
                            if (one_byte_msg) begin
                                complete = 1'b1;
                                msg_d1   = byte_in[6:0];
                                state_n  = WAIT_STATUS;
                            end else begin
                                state_n = DATA2;
                            end
                        end else if (err_q != 8'hFF) begin
                            err_n = err_q + 8'd1;
                        end
                    end
                    DATA2: begin
                        complete = 1'b1;
                        msg_d2   = byte_in[6:0];
                        state_n  = WAIT_STATUS;
                    end
                    SKIP: begin
                        skip_n = skip_q - 2'd1;
                        if (skip_q <= 2'd1) begin
                            state_n = WAIT_STATUS;
                        end
                    end
                    default: begin
                        // SYSEX payload is discarded.
                    end
                endcase
            end
        end

        if (complete && chan_ok) begin
            if (rs_q[7:4] == 4'h9 && msg_d2 != 7'd0) begin
                note_n = msg_d1;
                vel_n  = msg_d2;
                gate_n = 1'b1;
                on_n   = 1'b1;
            end else if ((rs_q[7:4] == 4'h8 || rs_q[7:4] == 4'h9) &&
                         gate_q && msg_d1 == note_q) begin
                gate_n = 1'b0;
                off_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= WAIT_STATUS;
            rs_q       <= 8'd0;
            rs_valid_q <= 1'b0;
            d1_q       <= 7'd0;
            skip_q     <= 2'd0;
            err_q      <= 8'd0;
            note_q     <= 7'd0;
            vel_q      <= 7'd0;
            gate_q     <= 1'b0;
            on_q       <= 1'b0;
            off_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            rs_q       <= rs_n;
            rs_valid_q <= rs_valid_n;
            d1_q       <= d1_n;
            skip_q     <= skip_n;
            err_q      <= err_n;
            note_q     <= note_n;
            vel_q      <= vel_n;
            gate_q     <= gate_n;
            on_q       <= on_n;
            off_q      <= off_n;
        end
    end

    assign note_on   = on_q;
    assign note_off  = off_q;
    assign note      = note_q;
    assign velocity  = vel_q;
    assign gate      = gate_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Testbench for midi_note_decoder (CHANNEL=0, OMNI=0).
// A byte-level reference model predicts the outputs after every cycle.

module tb_midi_note_decoder;

    localparam logic [3:0] CH     = 4'd0;
    localparam bit         OMNI_P = 1'b0;

    localparam int M_IDLE  = 0;
    localparam int M_MSG   = 1;
    localparam int M_SYSEX = 2;
    localparam int M_SKIP  = 3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic       note_on, note_off, gate;
    logic [6:0] note, velocity;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    midi_note_decoder #(.CHANNEL(CH), .OMNI(OMNI_P)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .note_on    (note_on),
        .note_off   (note_off),
        .note       (note),
        .velocity   (velocity),
        .gate       (gate),
        .err_count  (err_count)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_rs;          // running status, -1 when none
    int         m_mode;
    int         m_skip;
    logic [6:0] m_data[$];     // data bytes of the message being collected
    int         m_err;
    logic [6:0] m_note, m_vel;
    logic       m_gate, m_on, m_off;

    function automatic int msg_len(input int status);
        return (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_rs = -1; m_mode = M_IDLE; m_skip = 0; m_data.delete();
        m_err = 0; m_note = 0; m_vel = 0; m_gate = 0; m_on = 0; m_off = 0;
    endtask

    task automatic model_apply();
        logic [7:0] s;
        logic [6:0] d1, d2;
        s  = m_rs[7:0];
        d1 = m_data[0];
        d2 = (m_data.size() > 1) ? m_data[1] : 7'd0;
        if (!(OMNI_P || s[3:0] == CH)) return;
        if (s[7:4] == 4'h9 && d2 != 0) begin
            m_note = d1; m_vel = d2; m_gate = 1; m_on = 1;
        end else if ((s[7:4] == 4'h8 || s[7:4] == 4'h9) && m_gate && d1 == m_note) begin
            m_gate = 0; m_off = 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_on = 0; m_off = 0;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            m_data.delete();
            if (b < 8'hF0) begin
                m_rs = int'(b); m_mode = M_MSG;
            end else if (b == 8'hF0) begin
                m_rs = -1; m_mode = M_SYSEX;
            end else if (b == 8'hF7) begin
                m_mode = M_IDLE;
            end else if (b == 8'hF1 || b == 8'hF3) begin
                m_rs = -1; m_mode = M_SKIP; m_skip = 1;
            end else if (b == 8'hF2) begin
                m_rs = -1; m_mode = M_SKIP; m_skip = 2;
            end else begin
                m_rs = -1; m_mode = M_IDLE;
            end
            return;
        end
        if (m_mode == M_SYSEX) return;
        if (m_mode == M_SKIP) begin
            m_skip--;
            if (m_skip == 0) m_mode = M_IDLE;
            return;
        end
        if (m_rs < 0) begin
            if (m_err < 255) m_err++;
            return;
        end
        m_data.push_back(b[6:0]);
        if (m_data.size() == msg_len(m_rs)) begin
            model_apply();
            m_data.delete();
            m_mode = M_IDLE;
        end else begin
            m_mode = M_MSG;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".note_on"},  32'(note_on),   32'(m_on));
        check({tag, ".note_off"}, 32'(note_off),  32'(m_off));
        check({tag, ".note"},     32'(note),      32'(m_note));
        check({tag, ".velocity"}, 32'(velocity),  32'(m_vel));
        check({tag, ".gate"},     32'(gate),      32'(m_gate));
        check({tag, ".err"},      32'(err_count), 32'(m_err));
    endtask

    // ---------------- drivers (enter and leave on negedge) ----------------
    task automatic send(input logic [7:0] b, input string tag);
        byte_in    = b;
        byte_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        byte_valid = 1'b0;
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            m_on = 0; m_off = 0;
            @(negedge clk);
            check_outputs(tag);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_b      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        check_outputs(tag);
    endtask

    task automatic send_seq(input logic [7:0] s[$], input string tag);
        foreach (s[i]) send(s[i], tag);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 45) return ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(8'h3C + $urandom_range(0, 3));
        if (r < 60) return 8'(8'h90 + $urandom_range(0, 1));
        if (r < 72) return 8'(8'h80 + $urandom_range(0, 1));
        if (r < 76) return 8'(8'hC0 + $urandom_range(0, 1));
        if (r < 82) return 8'(8'hF8 + $urandom_range(0, 7));
        if (r < 85) return 8'hF0;
        if (r < 88) return 8'hF7;
        if (r < 93) return 8'(8'hF1 + $urandom_range(0, 5));
        return 8'($urandom_range(8'hA0, 8'hEF));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge clk);
        do_reset("reset");

        // T1 basic note-on
        send_seq('{8'h90, 8'h3C, 8'h64}, "t1");
        check("t1.strobe", 32'(note_on), 32'd1);
        check("t1.note", 32'(note), 32'h3C);
        idle(2, "t1.idle");

        // T2 running status, retrigger, note-off of an unheld note, then real release
        send_seq('{8'h40, 8'h50}, "t2.retrig");
        check("t2.retrig_note", 32'(note), 32'h40);
        send_seq('{8'h3C, 8'h00}, "t2.unheld_off");
        send_seq('{8'h80, 8'h40, 8'h00}, "t2.off");
        check("t2.off_strobe", 32'(note_off), 32'd1);
        check("t2.gate", 32'(gate), 32'd0);

        // T3 realtime interleaving, then wrong channel
        do_reset("t3.reset");
        send_seq('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64}, "t3.rt");
        check("t3.rt_note", 32'(note), 32'h3C);
        send_seq('{8'h91, 8'h3C, 8'h64}, "t3.chan");

        // T4 abort by sysex, dropped byte, program change then note-on
        do_reset("t4.reset");
        send_seq('{8'h90, 8'h3C, 8'hF0, 8'h11, 8'h22, 8'hF7, 8'h64}, "t4.abort");
        check("t4.err", 32'(err_count), 32'd1);
        send_seq('{8'hC0, 8'h05, 8'h90, 8'h3C, 8'h7F}, "t4.pc");

        // T5 reset mid-message
        send_seq('{8'h90, 8'h3C}, "t5.part");
        do_reset("t5.reset");
        send(8'h64, "t5.after");
        check("t5.err", 32'(err_count), 32'd1);

        // T6 saturation
        do_reset("t6.reset");
        for (int i = 0; i < 300; i++) send(8'h11, "t6");
        check("t6.sat", 32'(err_count), 32'd255);

        // Randomized stream with gaps and occasional resets
        do_reset("rnd.reset");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd.reset");
            send(rand_byte(), "rnd");
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), "rnd.gap");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
